modu_sweep_ctrl: RTL and testbench

- Exhaustive stimulus sequencer for the 4-input combinational `modu` datapath (A, B 1 bit; C, D 2 bit; F 3 bit).
- On `start`, it drives every input combination in order, with A as the fastest-changing input and D the slowest.
- It holds each vector for a programmable number of settle cycles, then captures F.
- Each capture is streamed out over a valid/ready handshake and added into a running signature, so the sweep can run on silicon without a software bench.

---
 rtl/modu_pkg.sv | 19 +
 rtl/sweep_hold_timer.sv | 30 +++
 rtl/modu_sweep_ctrl.sv | 113 +++++++++++
 tb/tb_modu_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modu_pkg.sv
// Shared widths and state encoding for the modu exhaustive-sweep controller.
package modu_pkg;

    localparam int WA      = 1;
    localparam int WB      = 1;
    localparam int WC      = 2;
    localparam int WD      = 2;
    localparam int WF      = 3;
    localparam int NV_W    = WA + WB + WC + WD;
    localparam int SUM_W   = WF + NV_W;
    localparam int NUM_VEC = 1 << NV_W;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_hold_timer.sv
// Settle counter: counts up to HOLD-1 and saturates there until cleared.
module sweep_hold_timer #(
    parameter int HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic freeze,
    output logic expired
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] cnt;

    // Saturation at LAST is what freezes the count while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!freeze && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/modu_sweep_ctrl.sv
// Drives every {D,C,B,A} combination into modu, captures F after HOLD cycles,
// streams each capture over valid/ready and accumulates a running signature.
module modu_sweep_ctrl
    import modu_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WA-1:0]    A,
    output logic [WB-1:0]    B,
    output logic [WC-1:0]    C,
    output logic [WD-1:0]    D,
    input  logic [WF-1:0]    F,
    output logic             samp_vld,
    input  logic             samp_rdy,
    output logic [NV_W-1:0]  samp_idx,
    output logic [WF-1:0]    samp_f,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sig
);

    sweep_state_t    state, state_nxt;
    logic [NV_W-1:0] idx;
    logic            expired;
    logic            start_acc;
    logic            cap;
    logic            last_vec;

    function automatic logic [SUM_W-1:0] sig_add(input logic [SUM_W-1:0] acc,
                                                 input logic [WF-1:0]    f);
        return acc + SUM_W'(f);
    endfunction

    assign last_vec     = (idx == NV_W'(NUM_VEC - 1));
    assign {D, C, B, A} = idx;

    sweep_hold_timer #(
        .HOLD(HOLD)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_acc || (cap && !last_vec)),
        .freeze (state != DRIVE),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                // A pending, unaccepted sample blocks the capture; it retries every cycle.
                if (expired && (!samp_vld || samp_rdy)) begin
                    cap = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            samp_vld <= 1'b0;
            samp_idx <= '0;
            samp_f   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sig      <= '0;
        end else if (start_acc) begin
            idx      <= '0;
            samp_vld <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            sig      <= '0;
        end else if (cap) begin
            samp_f   <= F;
            samp_idx <= idx;
            samp_vld <= 1'b1;
            sig      <= sig_add(sig, F);
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (samp_vld && samp_rdy) begin
            samp_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modu_sweep_ctrl.sv
// Bench for modu_sweep_ctrl: two instances (HOLD=1 and HOLD=3) with a modu model F=C+D.
module tb_modu_sweep_ctrl;
    import modu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start1, rdy1, start3, rdy3, glitch3;

    logic [WA-1:0] a1, a3;
    logic [WB-1:0] b1, b3;
    logic [WC-1:0] c1, c3;
    logic [WD-1:0] d1, d3;
    logic [WF-1:0] f1, f3, f3_true;
    logic            vld1, vld3, busy1, busy3, done1, done3;
    logic [NV_W-1:0] sidx1, sidx3;
    logic [WF-1:0]   sf1, sf3;
    logic [SUM_W-1:0] sig1, sig3;

    assign f1      = WF'(c1) + WF'(d1);
    assign f3_true = WF'(c3) + WF'(d3);
    assign f3      = glitch3 ? (f3_true ^ 3'b111) : f3_true;

    modu_sweep_ctrl #(.HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .C(c1), .D(d1), .F(f1),
        .samp_vld(vld1), .samp_rdy(rdy1), .samp_idx(sidx1), .samp_f(sf1),
        .busy(busy1), .done(done1), .sig(sig1)
    );

    modu_sweep_ctrl #(.HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .A(a3), .B(b3), .C(c3), .D(d3), .F(f3),
        .samp_vld(vld3), .samp_rdy(rdy3), .samp_idx(sidx3), .samp_f(sf3),
        .busy(busy3), .done(done3), .sig(sig3)
    );

    typedef struct packed {
        logic [NV_W-1:0] idx;
        logic [WF-1:0]   f;
    } samp_t;

    samp_t q1[$];
    samp_t q3[$];
    samp_t e1, e3;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [WF-1:0] f_model(input int i);
        logic [NV_W-1:0] v;
        v = NV_W'(i);
        return WF'(v[3:2]) + WF'(v[5:4]);
    endfunction

    task automatic push_all(input bit to_q3);
        for (int i = 0; i < NUM_VEC; i++) begin
            samp_t e;
            e.idx = NV_W'(i);
            e.f   = f_model(i);
            if (to_q3) q3.push_back(e);
            else       q1.push_back(e);
        end
    endtask

    task automatic pulse_start1();
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic pulse_start3();
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
    endtask

    // Scoreboard monitors: every accepted sample must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en && vld1 && rdy1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_sample actual_idx=%0d required=none", sidx1);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_samp_idx", int'(sidx1), int'(e1.idx));
                chk("dut1_samp_f", int'(sf1), int'(e1.f));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && vld3 && rdy3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut3_unexpected_sample actual_idx=%0d required=none", sidx3);
            end else begin
                e3 = q3.pop_front();
                chk("dut3_samp_idx", int'(sidx3), int'(e3.idx));
                chk("dut3_samp_f", int'(sf3), int'(e3.f));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        rdy1 = 1'b1; rdy3 = 1'b1; glitch3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_sig", int'(sig1), 0);
        chk("rst_vld", int'(vld1), 0);
        chk("rst_vec", int'({d1, c1, b1, a1}), 0);
        chk("rst_busy3", int'(busy3), 0);
        @(negedge clk) rst = 1'b0;

        // Asynchronous reset in the middle of a sweep
        pulse_start1();
        repeat (17) @(posedge clk);
        #1 chk("pre_rst_vec", int'({d1, c1, b1, a1}), 17);
        chk("pre_rst_busy", int'(busy1), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vec", int'({d1, c1, b1, a1}), 0);
        chk("async_rst_vld", int'(vld1), 0);
        chk("async_rst_idx", int'(sidx1), 0);
        chk("async_rst_f", int'(sf1), 0);
        chk("async_rst_busy", int'(busy1), 0);
        chk("async_rst_done", int'(done1), 0);
        chk("async_rst_sig", int'(sig1), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("idle_after_rst_busy", int'(busy1), 0);
        @(negedge clk) mon_en = 1'b1;

        // Full sweep, HOLD=1, restarting from idx 0
        push_all(1'b0);
        pulse_start1();
        chk("sw1_busy", int'(busy1), 1);
        chk("sw1_vec0", int'({d1, c1, b1, a1}), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("sw1_a_idx5", int'(a1), 1);
        chk("sw1_b_idx5", int'(b1), 0);
        chk("sw1_c_idx5", int'(c1), 1);
        chk("sw1_d_idx5", int'(d1), 0);
        chk("sw1_f_idx5", int'(f1), 1);
        repeat (58) @(posedge clk);
        #1 chk("sw1_done_t63", int'(done1), 0);
        @(posedge clk);
        #1;
        chk("sw1_done_t64", int'(done1), 1);
        chk("sw1_busy_t64", int'(busy1), 0);
        chk("sw1_vld_t64", int'(vld1), 1);
        chk("sw1_idx_t64", int'(sidx1), 63);
        chk("sw1_sig", int'(sig1), 192);
        repeat (3) @(posedge clk);
        #1;
        chk("sw1_drained", q1.size(), 0);
        chk("sw1_vld_clear", int'(vld1), 0);
        chk("sw1_last_vec", int'({d1, c1, b1, a1}), 63);

        // Backpressure on sample 10; start in DONE clears sig and done
        push_all(1'b0);
        pulse_start1();
        chk("sw2_sig_cleared", int'(sig1), 0);
        chk("sw2_done_fell", int'(done1), 0);
        repeat (11) @(posedge clk);
        #1 rdy1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_vld", int'(vld1), 1);
            chk("bp_idx", int'(sidx1), 10);
            chk("bp_f", int'(sf1), 2);
            chk("bp_vec", int'({d1, c1, b1, a1}), 11);
        end
        rdy1 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idx", int'(sidx1), 11);
        chk("bp_release_vld", int'(vld1), 1);
        repeat (51) @(posedge clk);
        #1 chk("sw2_done_early", int'(done1), 0);
        @(posedge clk);
        #1;
        chk("sw2_done", int'(done1), 1);
        chk("sw2_sig", int'(sig1), 192);
        repeat (3) @(posedge clk);

        // Start pulse while busy is ignored
        push_all(1'b0);
        pulse_start1();
        repeat (20) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        chk("sw3_busy_start_ignored", int'({d1, c1, b1, a1}), 21);
        repeat (42) @(posedge clk);
        #1 chk("sw3_done_early", int'(done1), 0);
        @(posedge clk);
        #1;
        chk("sw3_done", int'(done1), 1);
        chk("sw3_sig", int'(sig1), 192);
        repeat (3) @(posedge clk);

        // HOLD=3 sweep; F corrupted on every non-capture cycle
        push_all(1'b1);
        pulse_start3();
        for (int k = 0; k < 192; k++) begin
            glitch3 = ((k % 3) != 2);
            @(posedge clk);
            #1;
            if (k == 2) chk("h3_first_vld", int'(vld3), 1);
            if (k == 4) chk("h3_idx_hold", int'(sidx3), 0);
            if (k == 5) chk("h3_idx_next", int'(sidx3), 1);
            if (k == 190) chk("h3_done_early", int'(done3), 0);
        end
        glitch3 = 1'b0;
        chk("h3_done", int'(done3), 1);
        chk("h3_idx63", int'(sidx3), 63);
        chk("h3_sig", int'(sig3), 192);

        for (int w = 0; w < 20 && (q1.size() != 0 || q3.size() != 0); w++) @(posedge clk);
        #1;
        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
